// File: rtl/pipe_seq_ctrl_if.sv
// Handshake bundle between the pipeline datapath/hazard unit and the
// sequencing controller. The master side is the datapath, the slave side
// is pipe_seq_ctrl.
interface pipe_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_stall_req;
  logic                  i_irq;
  logic                  i_irq_en;
  logic                  i_eret_de;
  logic [ADDR_WIDTH-1:0] i_pc_de;

  logic                  o_pc_en;
  logic                  o_fd_en;
  logic                  o_fd_flush;
  logic                  o_de_flush;
  logic [1:0]            o_pc_sel;
  logic [ADDR_WIDTH-1:0] o_epc;
  logic                  o_epc_we;
  logic                  o_int_ack;
  logic                  o_in_isr;
  logic [15:0]           o_stall_cnt;

  modport master (
    output i_stall_req, i_irq, i_irq_en, i_eret_de, i_pc_de,
    input  o_pc_en, o_fd_en, o_fd_flush, o_de_flush, o_pc_sel,
           o_epc, o_epc_we, o_int_ack, o_in_isr, o_stall_cnt
  );

  modport slave (
    input  i_stall_req, i_irq, i_irq_en, i_eret_de, i_pc_de,
    output o_pc_en, o_fd_en, o_fd_flush, o_de_flush, o_pc_sel,
           o_epc, o_epc_we, o_int_ack, o_in_isr, o_stall_cnt
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: handles hazard stalls, drains the back end
// before taking an interrupt or returning from one (ERET), and redirects the
// PC to the interrupt vector or the saved EPC. Stall/redirect controls are
// combinational from state and inputs so a stall takes effect the same cycle.
module pipe_seq_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  pipe_seq_ctrl_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TRAP   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  localparam logic       KIND_IRQ  = 1'b0;
  localparam logic       KIND_ERET = 1'b1;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t                r_state;
  logic [3:0]            r_drain_cnt;
  logic                  r_kind;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic                  r_in_isr;
  logic [15:0]           r_stall_cnt;

  logic       w_eret_ev;
  logic       w_irq_ev;
  logic       w_pc_en;
  logic       w_fd_en;
  logic       w_fd_flush;
  logic       w_de_flush;
  logic [1:0] w_pc_sel;
  logic       w_epc_we;
  logic       w_int_ack;

  // Cycle counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ERET only counts inside a handler; an ERET in decode also masks the
  // interrupt so ERET wins when both arrive together.
  assign w_eret_ev = (r_state == ST_RUN) && io_bus.i_eret_de && r_in_isr;
  assign w_irq_ev  = (r_state == ST_RUN) && io_bus.i_irq && io_bus.i_irq_en &&
                     !r_in_isr && !io_bus.i_eret_de;

  // Decode pipeline control from the current state and this cycle's inputs.
  always_comb begin
    w_pc_en    = 1'b1;
    w_fd_en    = 1'b1;
    w_fd_flush = 1'b0;
    w_de_flush = 1'b0;
    w_pc_sel   = 2'b00;
    w_epc_we   = 1'b0;
    w_int_ack  = 1'b0;
    if (i_rst) begin
      w_pc_en    = 1'b0;
      w_fd_en    = 1'b0;
      w_fd_flush = 1'b1;
      w_de_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_eret_ev || w_irq_ev || io_bus.i_stall_req) begin
            w_pc_en    = 1'b0;
            w_fd_en    = 1'b0;
            w_de_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          w_pc_en    = 1'b0;
          w_fd_en    = 1'b0;
          w_de_flush = 1'b1;
        end
        ST_TRAP: begin
          w_pc_sel   = 2'b01;
          w_fd_flush = 1'b1;
          w_de_flush = 1'b1;
          w_epc_we   = 1'b1;
          w_int_ack  = 1'b1;
        end
        ST_RETURN: begin
          w_pc_sel   = 2'b10;
          w_fd_flush = 1'b1;
          w_de_flush = 1'b1;
        end
        default: begin
          w_pc_en = 1'b0;
          w_fd_en = 1'b0;
        end
      endcase
    end
  end

  // Sequencing FSM: RUN -> DRAIN (DRAIN_CYCLES cycles) -> TRAP/RETURN -> RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 4'd0;
      r_kind      <= KIND_IRQ;
      r_epc       <= '0;
      r_in_isr    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_eret_ev) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_kind      <= KIND_ERET;
            r_state     <= ST_DRAIN;
          end else if (w_irq_ev) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_kind      <= KIND_IRQ;
            r_epc       <= io_bus.i_pc_de;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - 4'd1;
          if (r_drain_cnt == 4'd1) begin
            r_state <= (r_kind == KIND_ERET) ? ST_RETURN : ST_TRAP;
          end
        end
        ST_TRAP: begin
          r_in_isr <= 1'b1;
          r_state  <= ST_RUN;
        end
        ST_RETURN: begin
          r_in_isr <= 1'b0;
          r_state  <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Count every non-reset cycle in which the PC is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= 16'd0;
    end else if (!w_pc_en) begin
      r_stall_cnt <= sat_inc16(r_stall_cnt);
    end
  end

  assign io_bus.o_pc_en     = w_pc_en;
  assign io_bus.o_fd_en     = w_fd_en;
  assign io_bus.o_fd_flush  = w_fd_flush;
  assign io_bus.o_de_flush  = w_de_flush;
  assign io_bus.o_pc_sel    = w_pc_sel;
  assign io_bus.o_epc       = r_epc;
  assign io_bus.o_epc_we    = w_epc_we;
  assign io_bus.o_int_ack   = w_int_ack;
  assign io_bus.o_in_isr    = r_in_isr;
  assign io_bus.o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Testbench for pipe_seq_ctrl: directed scenarios followed by random traffic,
// checked cycle by cycle against a schedule-based reference model.
module tb_pipe_seq_ctrl;

  localparam int AW    = 32;
  localparam int DRAIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_seq_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  pipe_seq_ctrl #(.ADDR_WIDTH(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [7:0]  ctrl;   // pc_en, fd_en, fd_flush, de_flush, pc_sel[1:0], epc_we, int_ack
    logic        in_isr;
    logic [31:0] epc;
    logic [15:0] cnt;
    logic        known;
  } exp_t;

  typedef enum int {A_FREEZE, A_TRAP, A_RET} act_e;

  exp_t exp_q[$];
  act_e plan[$];

  logic        m_known = 1'b0;
  logic        m_in_isr = 1'b0;
  logic [31:0] m_epc = '0;
  logic [15:0] m_cnt = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  // Reference: an event schedules DRAIN freeze cycles then one redirect cycle.
  task automatic cyc(input logic r, input logic s, input logic q, input logic qe,
                     input logic e, input logic [31:0] pc);
    exp_t x;
    act_e a;
    logic pc_en, fd_en, fd_fl, de_fl, ewe, ack;
    logic [1:0] sel;
    logic irq_ev, eret_ev, took_trap, took_ret;
    @(posedge clk);
    #1;
    rst = r;
    bus.i_stall_req = s;
    bus.i_irq = q;
    bus.i_irq_en = qe;
    bus.i_eret_de = e;
    bus.i_pc_de = pc;
    pc_en = 1'b1; fd_en = 1'b1; fd_fl = 1'b0; de_fl = 1'b0;
    sel = 2'b00; ewe = 1'b0; ack = 1'b0;
    took_trap = 1'b0; took_ret = 1'b0; irq_ev = 1'b0; eret_ev = 1'b0;
    if (r) begin
      pc_en = 1'b0; fd_en = 1'b0; fd_fl = 1'b1; de_fl = 1'b1;
    end else if (plan.size() > 0) begin
      a = plan.pop_front();
      if (a == A_FREEZE) begin
        pc_en = 1'b0; fd_en = 1'b0; de_fl = 1'b1;
      end else if (a == A_TRAP) begin
        sel = 2'b01; fd_fl = 1'b1; de_fl = 1'b1; ewe = 1'b1; ack = 1'b1;
        took_trap = 1'b1;
      end else begin
        sel = 2'b10; fd_fl = 1'b1; de_fl = 1'b1;
        took_ret = 1'b1;
      end
    end else begin
      eret_ev = e && m_in_isr;
      irq_ev  = q && qe && !m_in_isr && !e;
      if (eret_ev || irq_ev || s) begin
        pc_en = 1'b0; fd_en = 1'b0; de_fl = 1'b1;
      end
      if (eret_ev || irq_ev) begin
        for (int k = 0; k < DRAIN; k++) plan.push_back(A_FREEZE);
        plan.push_back(eret_ev ? A_RET : A_TRAP);
      end
    end
    x.ctrl   = {pc_en, fd_en, fd_fl, de_fl, sel, ewe, ack};
    x.in_isr = m_in_isr;
    x.epc    = m_epc;
    x.cnt    = m_cnt;
    x.known  = m_known;
    exp_q.push_back(x);
    if (r) begin
      plan.delete();
      m_known = 1'b1; m_in_isr = 1'b0; m_epc = '0; m_cnt = '0;
    end else begin
      if (!pc_en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (irq_ev) m_epc = pc;
      if (took_trap) m_in_isr = 1'b1;
      if (took_ret) m_in_isr = 1'b0;
    end
  endtask

  // Monitor: pop the expected response for each presented cycle and compare.
  initial begin : monitor
    exp_t e;
    logic [7:0]  g_ctrl;
    logic [48:0] g_regs;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g_ctrl = {bus.o_pc_en, bus.o_fd_en, bus.o_fd_flush, bus.o_de_flush,
                  bus.o_pc_sel, bus.o_epc_we, bus.o_int_ack};
        n_cmp++;
        if (g_ctrl !== e.ctrl) begin
          n_bad++;
          $display("FAIL ctrl cyc=%0d got=%b expected=%b", cycle, g_ctrl, e.ctrl);
        end
        if (e.known) begin
          g_regs = {bus.o_in_isr, bus.o_epc, bus.o_stall_cnt};
          n_cmp++;
          if (g_regs !== {e.in_isr, e.epc, e.cnt}) begin
            n_bad++;
            $display("FAIL regs cyc=%0d got isr=%b epc=%h cnt=%h expected isr=%b epc=%h cnt=%h",
                     cycle, bus.o_in_isr, bus.o_epc, bus.o_stall_cnt, e.in_isr, e.epc, e.cnt);
          end
        end
      end
    end
  end

  initial begin : stim
    bus.i_stall_req = 1'b0;
    bus.i_irq = 1'b0;
    bus.i_irq_en = 1'b0;
    bus.i_eret_de = 1'b0;
    bus.i_pc_de = '0;

    repeat (2) cyc(1, 0, 0, 0, 0, 32'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 32'h0);
    // two-cycle hazard stall
    repeat (2) cyc(0, 1, 0, 0, 0, 32'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 32'h0);
    // interrupt held high: trap, then ignored while in handler
    cyc(0, 0, 1, 1, 0, 32'h0000_0040);
    repeat (8) cyc(0, 0, 1, 1, 0, 32'h0000_0044);
    // ERET with irq still high: return, then the interrupt re-triggers
    cyc(0, 0, 1, 1, 1, 32'h0000_0080);
    repeat (10) cyc(0, 0, 1, 1, 0, 32'h0000_0084);
    // ERET and interrupt in the same cycle inside the handler
    cyc(0, 0, 1, 1, 1, 32'h0000_00C0);
    repeat (6) cyc(0, 0, 0, 0, 0, 32'h0);
    // reset on the second drain cycle
    cyc(0, 0, 1, 1, 0, 32'h0000_0100);
    cyc(0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0);
    repeat (4) cyc(0, 0, 0, 0, 0, 32'h0);
    // long stall to reach counter saturation
    cyc(1, 0, 0, 0, 0, 32'h0);
    repeat (70000) cyc(0, 1, 0, 0, 0, 32'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 32'h0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0),
          32'($urandom));
    end
    repeat (2) cyc(0, 0, 0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue got=%0d pending expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning PC/EPC width.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of flush cycles needed to empty EX/MA/WB (legal range 1..15).
REQ-003 SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_stall_req  in  1  data-hazard stall request from the hazard unit.
REQ-006 SHALL have port i_irq  in  1  level-sensitive external interrupt.
REQ-007 SHALL have port i_irq_en  in  1  global interrupt enable.
REQ-008 SHALL have port i_eret_de  in  1  ERET present in decode.
REQ-009 SHALL have port i_pc_de  in  ADDR_WIDTH  PC of the instruction in decode.
REQ-010 SHALL have port o_pc_en  out  1  PC register enable.
REQ-011 SHALL have port o_fd_en  out  1  IF/DE pipeline register enable.
REQ-012 SHALL have port o_fd_flush  out  1  clear IF/DE (bubble into decode).
REQ-013 SHALL have port o_de_flush  out  1  clear DE/EX (bubble into execute).
REQ-014 SHALL have port o_pc_sel  out  2  next-PC select: 00 sequential/branch, 01 interrupt vector, 10 EPC.
REQ-015 SHALL have port o_epc  out  ADDR_WIDTH  saved exception PC.
REQ-016 SHALL have port o_epc_we  out  1  one-cycle EPC commit strobe.
REQ-017 SHALL have port o_int_ack  out  1  one-cycle interrupt acknowledge.
REQ-018 SHALL have port o_in_isr  out  1  handler active flag.
REQ-019 SHALL have port o_stall_cnt  out  16  count of cycles with o_pc_en=0.

Function
REQ-020 SHALL implement FSM states RUN, DRAIN, TRAP, RETURN plus a 1-bit trap/return kind register and a 4-bit drain counter.
REQ-021 SHALL, in RUN with no event: o_pc_en=1, o_fd_en=1, both flushes 0, o_pc_sel=00.
REQ-022 SHALL, in RUN with i_stall_req=1 and no event: o_pc_en=0, o_fd_en=0, o_de_flush=1, o_fd_flush=0, same cycle (combinational), state stays RUN.
REQ-023 SHALL treat an interrupt event as i_irq & i_irq_en & !o_in_isr & !i_eret_de in RUN.
REQ-024 SHALL treat an ERET event as i_eret_de & o_in_isr in RUN; ERET with o_in_isr=0 is ignored (normal RUN behaviour).
REQ-025 SHALL, on an event in RUN: load drain counter with DRAIN_CYCLES, record kind, go to DRAIN; for interrupt also capture i_pc_de into o_epc next edge; that cycle outputs as REQ-022 (freeze, de_flush=1).
REQ-026 SHALL, in DRAIN: o_pc_en=0, o_fd_en=0, o_de_flush=1, decrement counter each cycle; ignore i_stall_req, i_irq, i_eret_de.
REQ-027 SHALL leave DRAIN when counter==1 at the edge, to TRAP (interrupt) or RETURN (ERET); drain occupies exactly DRAIN_CYCLES cycles.
REQ-028 SHALL, in TRAP (one cycle): o_pc_sel=01, o_pc_en=1, o_fd_flush=1, o_de_flush=1, o_epc_we=1, o_int_ack=1; set o_in_isr next edge; go to RUN.
REQ-029 SHALL, in RETURN (one cycle): o_pc_sel=10, o_pc_en=1, o_fd_flush=1, o_de_flush=1; clear o_in_isr next edge; go to RUN.
REQ-030 SHALL give ERET priority over interrupt when both present in the same RUN cycle; both override i_stall_req.
REQ-031 SHALL increment o_stall_cnt on every cycle with o_pc_en=0 outside reset, saturating at 16'hFFFF.
REQ-032 SHALL hold o_epc unchanged except on interrupt capture.

Reset
REQ-033 SHALL, while i_rst=1: o_pc_en=0, o_fd_en=0, o_fd_flush=1, o_de_flush=1, o_pc_sel=00, o_epc_we=0, o_int_ack=0.
REQ-034 SHALL, at the reset edge: state=RUN, counter=0, kind=0, o_epc=0, o_in_isr=0, o_stall_cnt=0.
REQ-035 SHALL abort any DRAIN/TRAP/RETURN in progress on reset with no EPC write or ack.

Verification
REQ-036 SHALL check: i_stall_req=1 for 2 cycles in RUN -> o_pc_en=0, o_de_flush=1 for exactly 2 cycles, o_stall_cnt=2.
REQ-037 SHALL check: i_irq=1, i_irq_en=1, i_pc_de=32'h0000_0040 -> 3 freeze cycles, then TRAP cycle with o_pc_sel=01, o_epc_we=1, o_int_ack=1, o_epc=32'h40, then o_in_isr=1.
REQ-038 SHALL check: with o_in_isr=1, i_eret_de=1 -> 3 drain cycles, RETURN with o_pc_sel=10, o_in_isr=0 after; further i_irq held high then re-triggers a trap.
REQ-039 SHALL check: i_irq=1 and i_eret_de=1 same cycle with o_in_isr=1 -> RETURN path, no o_int_ack.
REQ-040 SHALL check: i_rst=1 on 2nd DRAIN cycle -> next cycle state RUN, o_in_isr=0, o_stall_cnt=0, no o_epc_we pulse.
REQ-041 SHALL check: stall held 70000 cycles -> o_stall_cnt stops at 16'hFFFF.
